piso: RTL and testbench

- Parallel-in, serial-out word serializer for the AES-over-UART datapath.
- Captures a 128-bit block, such as an AES ciphertext or plaintext, in one cycle.
- Emits the block one byte per clock, MSB byte first, toward the UART transmit path.
- Flags when it holds no more bytes to send.

---
 rtl/piso.sv | 95 +++++++++
 tb/tb_piso.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
`default_nettype none
// ============================================================================
// Module      : piso
// Description : Parallel-in, serial-out word serializer. Captures a
//               DATA_WIDTH block in one cycle and emits it OUT_WIDTH bits per
//               clock, MSB word first (or LSB word first when MSB_FIRST=0).
//               empty flags when no words remain to be emitted.
// Revision    : 1.0 - initial release
// ============================================================================
module piso #(
    parameter int DATA_WIDTH = 128,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    output logic [OUT_WIDTH-1:0]  serial_out,
    output logic                  out_valid,
    output logic                  empty
);

    localparam int NUM_WORDS = DATA_WIDTH / OUT_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(NUM_WORDS);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [OUT_WIDTH-1:0]  serial_q, serial_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;

    // Word presented next and the register contents after it is removed;
    // vacated bits fill with zero.
    logic [OUT_WIDTH-1:0]  w_next_word;
    logic [DATA_WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next_word = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
            assign w_shifted   = shift_q << OUT_WIDTH;
        end else begin : g_lsb_first
            assign w_next_word = shift_q[OUT_WIDTH-1:0];
            assign w_shifted   = shift_q >> OUT_WIDTH;
        end
    endgenerate

    // Next-state selection: load restarts, otherwise drain one word per clock.
    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        serial_d = serial_q;
        valid_d  = 1'b0;
        empty_d  = empty_q;
        if (load) begin
            // A reload discards any words still pending; nothing is emitted.
            shift_d = parallel_in;
            count_d = C_FULL_COUNT;
            empty_d = 1'b0;
        end else if (count_q != '0) begin
            serial_d = w_next_word;
            shift_d  = w_shifted;
            count_d  = count_q - 1'b1;
            valid_d  = 1'b1;
            // Rises together with the final word.
            empty_d  = (count_q == CNT_W'(1));
        end else begin
            empty_d = 1'b1;
        end
    end

    // State registers with asynchronous reset to the idle/empty condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            count_q  <= '0;
            serial_q <= '0;
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            shift_q  <= shift_d;
            count_q  <= count_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
        end
    end

    assign serial_out = serial_q;
    assign out_valid  = valid_q;
    assign empty      = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso
// Description : Self-checking bench for piso. Two instances (MSB-first and
//               LSB-first) share stimulus; a queue-based reference model
//               predicts every output after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso;

    logic         clk;
    logic         reset;
    logic         load;
    logic [127:0] parallel_in;

    logic [7:0]   so_m, so_l;
    logic         ov_m, ov_l, em_m, em_l;

    int errors = 0;
    int checks = 0;

    // Reference model state: words still to be emitted, in emission order.
    logic [7:0] qm[$];
    logic [7:0] ql[$];
    logic [7:0] m_so_m, m_so_l;
    logic       m_valid, m_empty;

    piso #(.DATA_WIDTH(128), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .parallel_in(parallel_in),
        .serial_out (so_m),
        .out_valid  (ov_m),
        .empty      (em_m)
    );

    piso #(.DATA_WIDTH(128), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .parallel_in(parallel_in),
        .serial_out (so_l),
        .out_valid  (ov_l),
        .empty      (em_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " msb.serial_out"}, so_m, m_so_m);
        chk({tag, " msb.out_valid"}, {7'd0, ov_m}, {7'd0, m_valid});
        chk({tag, " msb.empty"}, {7'd0, em_m}, {7'd0, m_empty});
        chk({tag, " lsb.serial_out"}, so_l, m_so_l);
        chk({tag, " lsb.out_valid"}, {7'd0, ov_l}, {7'd0, m_valid});
        chk({tag, " lsb.empty"}, {7'd0, em_l}, {7'd0, m_empty});
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        m_so_m  = 8'h00;
        m_so_l  = 8'h00;
        m_valid = 1'b0;
        m_empty = 1'b1;
    endtask

    // Model of one clock edge, from the behavioural rules of the serializer.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (load) begin
            qm.delete();
            ql.delete();
            for (int i = 0; i < 16; i++) begin
                qm.push_back(parallel_in[127 - 8*i -: 8]);
                ql.push_back(parallel_in[8*i +: 8]);
            end
            m_valid = 1'b0;
            m_empty = 1'b0;
        end else if (qm.size() > 0) begin
            m_so_m  = qm.pop_front();
            m_so_l  = ql.pop_front();
            m_valid = 1'b1;
            m_empty = (qm.size() == 0);
        end else begin
            m_valid = 1'b0;
            m_empty = 1'b1;
        end
    endtask

    // Drive inputs, take one clock edge, update the model, check 1 ns later.
    task automatic step(input logic ld, input logic [127:0] d, input string tag);
        load        = ld;
        parallel_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    localparam logic [127:0] C_BLK_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] C_BLK_B = 128'hFFEEDDCCBBAA99887766554433221100;

    initial begin
        logic [127:0] rnd;
        logic [7:0]   first_words[$];

        // Scenario 1: reset, then idle hold.
        reset       = 1'b1;
        load        = 1'b0;
        parallel_in = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, "idle_after_reset");

        // Scenario 2 and 6: basic serialization, both word orders.
        step(1'b1, C_BLK_A, "load_A");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, "serialize_A");
            if (ov_m === 1'b1) first_words.push_back(so_m);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, "after_A");
        // Directed spot checks of the documented byte order.
        chk("A_word0_msb", (first_words.size() > 0) ? first_words[0] : 8'hxx, 8'h01);
        chk("A_word15_msb", (first_words.size() > 15) ? first_words[15] : 8'hxx, 8'h10);
        chk("A_last_lsb", so_l, 8'h01);

        // Scenario 3: reload after 5 words.
        step(1'b1, C_BLK_A, "load_A2");
        for (int i = 0; i < 5; i++) step(1'b0, '0, "A2_words");
        step(1'b1, C_BLK_B, "reload_B");
        step(1'b0, '0, "B_word0");
        chk("B_word0_msb", so_m, 8'hFF);
        for (int i = 0; i < 17; i++) step(1'b0, '0, "B_words");

        // Scenario 4: asynchronous reset between edges during word 7.
        step(1'b1, C_BLK_A, "load_A3");
        for (int i = 0; i < 7; i++) step(1'b0, '0, "A3_words");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        step(1'b1, C_BLK_B, "reset_over_load");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, '0, "idle_after_async_reset");

        // Scenario 5: load held for three edges with changing data.
        step(1'b1, C_BLK_B, "hold_load_0");
        step(1'b1, {4{32'hDEADBEEF}}, "hold_load_1");
        step(1'b1, C_BLK_A, "hold_load_2");
        step(1'b0, '0, "hold_first_word");
        chk("hold_first_msb", so_m, 8'h01);
        for (int i = 0; i < 17; i++) step(1'b0, '0, "hold_words");

        // Randomized blocks and load timing.
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 19) == 0), rnd, "random");
        end
        for (int i = 0; i < 18; i++) step(1'b0, '0, "random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
